sparrow_branch_predictor: RTL and testbench

SPARROW_BRANCH_PREDICTOR -- requirements
Module: sparrow_branch_predictor

---
 rtl/sparrow_branch_predictor.sv | 153 +++++++++++++++
 tb/tb_sparrow_branch_predictor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparrow_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : sparrow_branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               counters, registered mispredict redirect and performance
//               counters for resolved / mispredicted conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
module sparrow_branch_predictor #(
  parameter int ENTRIES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic        upd_is_b_type_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  input  logic        flush_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_count_o,
  output logic [31:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  // Table storage
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic        r_redir_valid;
  logic [31:0] r_redir_pc;
  logic [31:0] r_br_count;
  logic [31:0] r_mis_count;

  logic [IDX_W-1:0] w_fidx;
  logic [TAG_W-1:0] w_ftag;
  logic             w_fhit;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic             w_u;
  logic             w_mis;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic [31:0]      w_redir_pc;
  logic             w_unused_bits;

  // PC word-offset bits never take part in indexing or tagging
  assign w_unused_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  assign w_fidx = fetch_pc_i[IDX_W+1:2];
  assign w_ftag = fetch_pc_i[31:IDX_W+2];
  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[31:IDX_W+2];

  assign w_u    = upd_valid_i & upd_is_b_type_i;
  assign w_mis  = w_u & ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  assign w_redir_pc = upd_taken_i ? upd_target_i : (upd_pc_i + 32'd4);

  // Zero-latency lookup; reads pre-update contents when an update hits the same index
  always_comb begin
    w_fhit        = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    pred_taken_o  = w_fhit && r_ctr[w_fidx][1];
    pred_target_o = pred_taken_o ? r_target[w_fidx] : 32'd0;
  end

  // Hit detection and saturating counter step for the resolving branch
  always_comb begin
    w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    w_ctr_cur = r_ctr[w_uidx];
    if (upd_taken_i) begin
      w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
    end else begin
      w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
    end
  end

  // Table training / allocation; flush only drops valid bits and beats any update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (w_u) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_ctr_next;
        if (upd_taken_i) begin
          r_target[w_uidx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target_i;
        r_ctr[w_uidx]    <= 2'b10;
      end
    end
  end

  // Redirect pulses one cycle after a mispredict; the PC holds between pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'd0;
    end else begin
      r_redir_valid <= w_mis;
      if (w_mis) begin
        r_redir_pc <= w_redir_pc;
      end
    end
  end

  // Saturating performance counters, independent of flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_br_count  <= 32'd0;
      r_mis_count <= 32'd0;
    end else begin
      if (w_u && (r_br_count != C_CNT_MAX)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_mis && (r_mis_count != C_CNT_MAX)) begin
        r_mis_count <= r_mis_count + 32'd1;
      end
    end
  end

  assign redirect_valid_o = r_redir_valid;
  assign redirect_pc_o    = r_redir_pc;
  assign br_count_o       = r_br_count;
  assign mispred_count_o  = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_sparrow_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparrow_branch_predictor
// Description : Scoreboard bench for sparrow_branch_predictor with a
//               behavioural table model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparrow_branch_predictor;

  localparam int ENT  = 32;
  localparam int IDXW = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic        upd_is_b_type_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        flush_i = 1'b0;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  sparrow_branch_predictor #(.ENTRIES(ENT)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fetch_pc_i       (fetch_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_valid_i      (upd_valid_i),
    .upd_is_b_type_i  (upd_is_b_type_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .flush_i          (flush_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .br_count_o       (br_count_o),
    .mispred_count_o  (mispred_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic t; logic [31:0] tg; } pred_t;
  typedef struct { logic rv; logic [31:0] rpc; logic [31:0] br; logic [31:0] mis; } st_t;

  pred_t pred_q[$];
  st_t   st_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit          mv   [ENT];
  logic [31:0] mtag [ENT];
  logic [31:0] mtgt [ENT];
  int          mctr [ENT];
  logic        m_rv;
  logic [31:0] m_rpc, m_br, m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 1;
    end
    m_rv = 1'b0; m_rpc = '0; m_br = '0; m_mis = '0;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = m_idx(pc);
    t  = mv[i] && (mtag[i] == m_tagof(pc)) && (mctr[i] >= 2);
    tg = t ? mtgt[i] : 32'd0;
  endfunction

  // Apply one cycle of stimulus and push the expected responses
  task automatic drive(input logic [31:0] fpc, input logic uv, input logic ub,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt, input logic fl);
    pred_t p;
    st_t   s;
    logic  u, m, hit;
    int    i;
    @(negedge clk_i);
    fetch_pc_i = fpc; upd_valid_i = uv; upd_is_b_type_i = ub; upd_pc_i = upc;
    upd_taken_i = ut; upd_target_i = utgt; upd_pred_taken_i = upt;
    upd_pred_target_i = uptgt; flush_i = fl;
    m_lookup(fpc, p.t, p.tg);
    pred_q.push_back(p);
    u = uv && ub;
    m = u && ((upt != ut) || (ut && (uptgt != utgt)));
    if (u && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (m && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    m_rv = m;
    if (m) m_rpc = ut ? utgt : upc + 32'd4;
    i   = m_idx(upc);
    hit = mv[i] && (mtag[i] == m_tagof(upc));
    if (fl) begin
      for (int k = 0; k < ENT; k++) mv[k] = 1'b0;
    end else if (u) begin
      if (hit) begin
        if (ut) begin
          mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
          mtgt[i] = utgt;
        end else begin
          mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        end
      end else if (ut) begin
        mv[i] = 1'b1; mtag[i] = m_tagof(upc); mtgt[i] = utgt; mctr[i] = 2;
      end
    end
    s.rv = m_rv; s.rpc = m_rpc; s.br = m_br; s.mis = m_mis;
    st_q.push_back(s);
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
  endfunction

  // Monitor: combinational prediction, sampled mid-cycle after the drive
  initial begin
    pred_t p;
    forever begin
      @(negedge clk_i); #2;
      if (mon_en && pred_q.size() > 0) begin
        p = pred_q.pop_front();
        chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, p.t});
        chk("pred_target", pred_target_o, p.tg);
      end
    end
  end

  // Monitor: registered outputs, sampled just after the active edge
  initial begin
    st_t s;
    forever begin
      @(posedge clk_i); #1;
      if (mon_en && st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, s.rv});
        chk("redirect_pc", redirect_pc_o, s.rpc);
        chk("br_count", br_count_o, s.br);
        chk("mispred_count", mispred_count_o, s.mis);
      end
    end
  end

  initial begin
    logic lt;
    logic [31:0] ltg, fpc, upc, utgt, uptgt;
    logic uv, ub, ut, upt, fl;

    m_reset();
    fetch_pc_i = 32'h100;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("rst_pred_target", pred_target_o, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_br_count", br_count_o, 32'd0);
    chk("rst_mispred_count", mispred_count_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Lookup after reset, then taken mispredict allocation
    idle(32'h100);
    drive(32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0);
    idle(32'h100);
    // Two not-taken resolutions walk the counter down
    drive(32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200, 0);
    drive(32'h100, 1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    idle(32'h100);
    // Aliasing: same index, different tag replaces occupant
    drive(32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0);
    drive(32'h180, 1, 1, 32'h180, 1, 32'h280, 0, 32'h0, 0);
    idle(32'h100);
    idle(32'h182);
    // Flush beats allocation but counters and redirect still act
    drive(32'h180, 1, 1, 32'h300, 1, 32'h340, 0, 32'h0, 1);
    idle(32'h300);
    idle(32'h180);
    // Non-branch update is ignored entirely
    drive(32'h300, 1, 0, 32'h300, 1, 32'h340, 0, 32'h0, 0);
    idle(32'h300);

    // Saturation of the resolved-branch counter
    @(posedge clk_i); #3;
    force dut.r_br_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_br_count;
    m_br = 32'hFFFF_FFFF;
    drive(32'h0, 1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0);
    drive(32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0, 0);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      fpc  = rnd_pc();
      upc  = ($urandom_range(0, 1) == 0) ? fpc : rnd_pc();
      uv   = ($urandom_range(0, 3) != 0);
      ub   = ($urandom_range(0, 4) != 0);
      ut   = 1'($urandom_range(0, 1));
      utgt = 32'h1000 + ($urandom_range(0, 3) << 2);
      m_lookup(upc, lt, ltg);
      if ($urandom_range(0, 3) != 0) begin
        upt = lt; uptgt = ltg;
      end else begin
        upt = 1'($urandom_range(0, 1));
        uptgt = 32'h1000 + ($urandom_range(0, 3) << 2);
      end
      fl = ($urandom_range(0, 15) == 0);
      drive(fpc, uv, ub, upc, ut, utgt, upt, uptgt, fl);
    end

    // Reset in the middle of a pending redirect
    drive(32'h100, 1, 1, 32'h100, 1, 32'h500, 0, 32'h0, 0);
    #3;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    upd_valid_i = 1'b0; upd_is_b_type_i = 1'b0; flush_i = 1'b0;
    fetch_pc_i = 32'h100;
    pred_q.delete();
    st_q.delete();
    m_reset();
    @(posedge clk_i); #1;
    chk("midrst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("midrst_redirect_pc", redirect_pc_o, 32'd0);
    chk("midrst_br_count", br_count_o, 32'd0);
    chk("midrst_mispred_count", mispred_count_o, 32'd0);
    chk("midrst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("postrst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("postrst_br_count", br_count_o, 32'd0);
    chk("postrst_pred_target", pred_target_o, 32'd0);
    mon_en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      fpc = rnd_pc();
      drive(fpc, 1, 1, fpc, 1'($urandom_range(0, 1)), 32'h2000, 0, 32'h0, 0);
    end
    repeat (3) @(posedge clk_i);
    #2;
    if (pred_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0", pred_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
